path_count_forward_pass: RTL and testbench
==========================================

Name: path_count_forward_pass

Overview:
- Initiator-side consumer of the topological order.
- Reads the node-index order stream produced by topological_sort and issues successor queries on the adjacency_map query/reply interface.
- Accumulates per-node path counts in internal RAM, then reports the count at end_node to the tap_encoder result path.
- Sits between topological_sort/adjacency_map and tap_encoder in user_logic.

Parameters:
- MAX_NODES, 1024, count RAM depth
- NODE_WIDTH, $clog2(MAX_NODES), node index width
- COUNT_WIDTH, 16, path count width; equals RESULT_WIDTH

Ports:
- clk  in  1  single clock (tck at top level)
- reset  in  1  synchronous, active-high
- start_node  in  NODE_WIDTH  source index; must be stable from reset deassertion until result_valid
- end_node  in  NODE_WIDTH  target index; same stability rule
- order_ready  out  1  accepts an order beat
- order_valid  in  1  topological order beat
- order_node  in  NODE_WIDTH  node index in topological order
- order_last  in  1  final node of the order
- query_ready  in  1  adjacency_map accepts a query
- query_valid  out  1  query request
- query_data  out  NODE_WIDTH  queried node
- reply_ready  out  1  accepts a reply beat
- reply_valid  in  1  successor beat
- reply_last  in  1  last successor for the query
- reply_data  in  NODE_WIDTH  successor index
- result_valid  out  1  one-cycle pulse
- result_data  out  COUNT_WIDTH  count[end_node]
- overflow  out  1  sticky; set when any accumulation carried out of COUNT_WIDTH

Behaviour:
- Reset: all outputs 0; state goes to CLEAR. Reset mid-operation abandons any in-flight query or reply; adjacency_map shares the same reset.
- CLEAR:
  - Writes count[a] for a = 0..MAX_NODES-1, one address per cycle.
  - Value written is 1 when a == start_node, else 0.
  - Goes to IDLE after MAX_NODES cycles. order_ready = 0 throughout.
- IDLE:
  - order_ready = 1.
  - On order_valid & order_ready: latch node and last; go to READ.
- READ:
  - One cycle for the RAM read (1-cycle latency); latch cur = count[node].
  - If node == end_node or cur == 0, skip querying: go to NEXT.
  - Otherwise go to QUERY.
- QUERY:
  - query_valid = 1, query_data = node; both held stable until query_ready.
  - Goes to REPLY on handshake.
- REPLY:
  - reply_ready = 1.
  - On a beat: latch dst; go to ACC_RD.
  - A leaf node is returned by adjacency_map as a single beat with reply_data == query_data and reply_last = 1. That beat is discarded with no RMW and goes to NEXT.
- ACC_RD: read count[dst].
- ACC_WR:
  - Write count[dst] + cur.
  - Go to NEXT if the latched reply_last = 1, else back to REPLY.
  - Each successor costs 3 cycles. reply_ready is low in ACC_RD and ACC_WR, so there is no RMW hazard.
- NEXT: go to FINAL if last, else IDLE.
- FINAL:
  - Read count[end_node]; the next cycle sets result_valid = 1 for one cycle, with result_data = value.
  - Go to DONE.
- DONE:
  - Terminal state; all ready/valid outputs are 0 until reset.
  - result_data holds its value.
- Arithmetic: unsigned COUNT_WIDTH add. Default behaviour is wrap-around modulo 2^COUNT_WIDTH; overflow is set on carry-out.
- Boundary conditions:
  - start_node == end_node: result is 1 if no other path contributes.
  - start_node never appears in the order: result is 0.
  - order_valid asserted during CLEAR is back-pressured.
  - reply_valid outside REPLY is ignored; adjacency_map must hold it.

Optional Feature:
- Macro: PATH_COUNT_SATURATE_EN.
- Defined: accumulation saturates at 2^COUNT_WIDTH-1; overflow still sets on the first clamp.
- Undefined: the add wraps as described in Behaviour.

Decomposition:
- Shared package aoc_graph_pkg holds:
  - NODE_WIDTH, MAX_NODES, COUNT_WIDTH constants
  - node_t and count_t typedefs
  - the state enum
- Sub-module count_ram: single-port, MAX_NODES x COUNT_WIDTH, registered read output with 1-cycle latency, write-first.
- The FSM stays in path_count_forward_pass.

Test Plan:
- Reset then idle: order_ready stays 0 for exactly 1024 cycles after reset falls, then goes to 1; all other outputs remain 0.
- Diamond graph with nodes 0->1, 0->2, 1->3, 2->3, leaf 3; start=0, end=3; order 0,1,2,3 -> result_valid pulse with result_data = 2, overflow = 0.
- Unreachable start: same graph with start=5 (absent from order) -> result_data = 0 and zero queries issued.
- query_ready held low for 7 cycles: query_valid and query_data stay stable; the reply beat is processed after the handshake. Injecting reply_valid gaps gives the same result, 2.
- Overflow: COUNT_WIDTH = 4 with a 17-path ladder.
  - Macro undefined: result 1, overflow = 1.
  - PATH_COUNT_SATURATE_EN defined: result 15, overflow = 1.
- Reset asserted in the middle of REPLY: all outputs 0 the next cycle and CLEAR restarts. A full rerun then gives the correct result, 2.

Source files
------------

// File: rtl/aoc_graph_pkg.sv
// ----------------------------------------------------------------------------
// aoc_graph_pkg
// Shared definitions for the graph path-counting blocks: default sizing
// constants, node/count typedefs and the forward-pass FSM state encoding.
// ----------------------------------------------------------------------------
package aoc_graph_pkg;

    localparam int MAX_NODES   = 1024;
    localparam int NODE_WIDTH  = $clog2(MAX_NODES);
    localparam int COUNT_WIDTH = 16;

    typedef logic [NODE_WIDTH-1:0]  node_t;
    typedef logic [COUNT_WIDTH-1:0] count_t;

    typedef enum logic [3:0] {
        ST_CLEAR  = 4'd0,
        ST_IDLE   = 4'd1,
        ST_READ   = 4'd2,
        ST_QUERY  = 4'd3,
        ST_REPLY  = 4'd4,
        ST_ACC_RD = 4'd5,
        ST_ACC_WR = 4'd6,
        ST_NEXT   = 4'd7,
        ST_FINAL  = 4'd8,
        ST_RESULT = 4'd9,
        ST_DONE   = 4'd10
    } state_e;

endpackage

// File: rtl/count_ram.sv
// ----------------------------------------------------------------------------
// count_ram
// Single-port DEPTH x WIDTH RAM holding per-node path counts.
// Registered read data (1-cycle latency), write-first: on a write cycle the
// read register captures the value being written.
//   clk   : clock
//   we    : write enable
//   addr  : read/write address
//   wdata : write data
//   rdata : registered read data
// ----------------------------------------------------------------------------
module count_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // No reset: the storage maps onto block RAM and is initialised by the
    // owning FSM's clear sweep.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata_q   <= wdata;
        end else begin
            rdata_q   <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/path_count_forward_pass.sv
// ----------------------------------------------------------------------------
// path_count_forward_pass
// Consumes a topological node order, queries each node's successors from the
// adjacency map and accumulates path counts from start_node in count_ram.
// After the last order beat, count[end_node] is reported with a 1-cycle
// result_valid pulse; the block then parks in DONE until reset.
//
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   start_node, end_node           : source / target index (held stable)
//   order_valid/ready/node/last    : topological order stream (sink)
//   query_valid/ready/data         : successor query (source)
//   reply_valid/ready/last/data    : successor replies (sink)
//   result_valid, result_data      : final count pulse, data held in DONE
//   overflow                       : sticky carry-out / clamp flag
//
// Build option: define PATH_COUNT_SATURATE_EN to clamp accumulation at the
// maximum count instead of wrapping.
// ----------------------------------------------------------------------------
module path_count_forward_pass #(
    parameter int MAX_NODES   = aoc_graph_pkg::MAX_NODES,
    parameter int NODE_WIDTH  = $clog2(MAX_NODES),
    parameter int COUNT_WIDTH = aoc_graph_pkg::COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NODE_WIDTH-1:0]  start_node,
    input  logic [NODE_WIDTH-1:0]  end_node,
    output logic                   order_ready,
    input  logic                   order_valid,
    input  logic [NODE_WIDTH-1:0]  order_node,
    input  logic                   order_last,
    input  logic                   query_ready,
    output logic                   query_valid,
    output logic [NODE_WIDTH-1:0]  query_data,
    output logic                   reply_ready,
    input  logic                   reply_valid,
    input  logic                   reply_last,
    input  logic [NODE_WIDTH-1:0]  reply_data,
    output logic                   result_valid,
    output logic [COUNT_WIDTH-1:0] result_data,
    output logic                   overflow
);

    import aoc_graph_pkg::*;

    localparam logic [NODE_WIDTH-1:0] LAST_ADDR = NODE_WIDTH'(MAX_NODES - 1);

    state_e                  state_q, state_d;
    logic [NODE_WIDTH-1:0]   clr_q, clr_d;
    logic [NODE_WIDTH-1:0]   node_q, node_d;
    logic                    last_q, last_d;
    logic [COUNT_WIDTH-1:0]  cur_q, cur_d;
    logic [NODE_WIDTH-1:0]   dst_q, dst_d;
    logic                    dlast_q, dlast_d;
    logic [COUNT_WIDTH-1:0]  result_q, result_d;
    logic                    overflow_q, overflow_d;

    logic                    ram_we;
    logic [NODE_WIDTH-1:0]   ram_addr;
    logic [COUNT_WIDTH-1:0]  ram_wdata;
    logic [COUNT_WIDTH-1:0]  ram_rdata;

    logic [COUNT_WIDTH:0]    sum_ext;
    logic                    carry;
    logic [COUNT_WIDTH-1:0]  acc_value;

    count_ram #(
        .DEPTH (MAX_NODES),
        .WIDTH (COUNT_WIDTH),
        .AW    (NODE_WIDTH)
    ) u_count_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // In ACC_WR the RAM output holds count[dst]; add the current node's count.
    assign sum_ext = {1'b0, ram_rdata} + {1'b0, cur_q};
    assign carry   = sum_ext[COUNT_WIDTH];

`ifdef PATH_COUNT_SATURATE_EN
    assign acc_value = carry ? {COUNT_WIDTH{1'b1}} : sum_ext[COUNT_WIDTH-1:0];
`else
    assign acc_value = sum_ext[COUNT_WIDTH-1:0];
`endif

    always_comb begin
        state_d      = state_q;
        clr_d        = clr_q;
        node_d       = node_q;
        last_d       = last_q;
        cur_d        = cur_q;
        dst_d        = dst_q;
        dlast_d      = dlast_q;
        result_d     = result_q;
        overflow_d   = overflow_q;

        ram_we       = 1'b0;
        ram_addr     = node_q;
        ram_wdata    = '0;

        order_ready  = 1'b0;
        query_valid  = 1'b0;
        query_data   = '0;
        reply_ready  = 1'b0;
        result_valid = 1'b0;
        result_data  = result_q;

        case (state_q)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = clr_q;
                ram_wdata = (clr_q == start_node) ? COUNT_WIDTH'(1) : '0;
                clr_d     = clr_q + 1'b1;
                if (clr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                order_ready = 1'b1;
                // Address the RAM with the incoming node so its count is
                // already on the read port during READ.
                ram_addr    = order_node;
                if (order_valid) begin
                    node_d  = order_node;
                    last_d  = order_last;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                cur_d = ram_rdata;
                // A zero count contributes nothing; the target's successors
                // can never reach it again in a DAG.
                if ((node_q == end_node) || (ram_rdata == '0)) begin
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_QUERY;
                end
            end
            ST_QUERY: begin
                query_valid = 1'b1;
                query_data  = node_q;
                if (query_ready) begin
                    state_d = ST_REPLY;
                end
            end
            ST_REPLY: begin
                reply_ready = 1'b1;
                if (reply_valid) begin
                    dst_d   = reply_data;
                    dlast_d = reply_last;
                    // A leaf is signalled by echoing the queried node back.
                    if (reply_last && (reply_data == node_q)) begin
                        state_d = ST_NEXT;
                    end else begin
                        state_d = ST_ACC_RD;
                    end
                end
            end
            ST_ACC_RD: begin
                ram_addr = dst_q;
                state_d  = ST_ACC_WR;
            end
            ST_ACC_WR: begin
                ram_we    = 1'b1;
                ram_addr  = dst_q;
                ram_wdata = acc_value;
                if (carry) begin
                    overflow_d = 1'b1;
                end
                state_d = dlast_q ? ST_NEXT : ST_REPLY;
            end
            ST_NEXT: begin
                state_d = last_q ? ST_FINAL : ST_IDLE;
            end
            ST_FINAL: begin
                ram_addr = end_node;
                state_d  = ST_RESULT;
            end
            ST_RESULT: begin
                result_valid = 1'b1;
                result_data  = ram_rdata;
                result_d     = ram_rdata;
                state_d      = ST_DONE;
            end
            ST_DONE: begin
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_q      <= '0;
            node_q     <= '0;
            last_q     <= 1'b0;
            cur_q      <= '0;
            dst_q      <= '0;
            dlast_q    <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_q      <= clr_d;
            node_q     <= node_d;
            last_q     <= last_d;
            cur_q      <= cur_d;
            dst_q      <= dst_d;
            dlast_q    <= dlast_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

endmodule

// File: tb/tb_path_count_forward_pass.sv
// ----------------------------------------------------------------------------
// tb_path_count_forward_pass
// Directed, table-driven bench. dut_a uses the default 16-bit count, dut_b a
// 4-bit count; both see identical stimulus. A behavioural adjacency map
// answers queries from a small successor table.
// ----------------------------------------------------------------------------
module tb_path_count_forward_pass;

    localparam int NW   = 10;
    localparam int CW   = 16;
    localparam int CW_B = 4;

`ifdef PATH_COUNT_SATURATE_EN
    localparam int LADDER_B = 15;
`else
    localparam int LADDER_B = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NW-1:0] start_node = '0;
    logic [NW-1:0] end_node = '0;
    logic          order_valid = 1'b0;
    logic [NW-1:0] order_node = '0;
    logic          order_last = 1'b0;
    logic          query_ready = 1'b0;
    logic          reply_valid = 1'b0;
    logic          reply_last = 1'b0;
    logic [NW-1:0] reply_data = '0;

    logic            a_order_ready, a_query_valid, a_reply_ready, a_result_valid, a_overflow;
    logic [NW-1:0]   a_query_data;
    logic [CW-1:0]   a_result_data;
    logic            b_order_ready, b_query_valid, b_reply_ready, b_result_valid, b_overflow;
    logic [NW-1:0]   b_query_data;
    logic [CW_B-1:0] b_result_data;

    always #5 clk = ~clk;

    path_count_forward_pass #(.MAX_NODES(1024), .NODE_WIDTH(NW), .COUNT_WIDTH(CW)) dut_a (
        .clk(clk), .reset(reset), .start_node(start_node), .end_node(end_node),
        .order_ready(a_order_ready), .order_valid(order_valid), .order_node(order_node),
        .order_last(order_last), .query_ready(query_ready), .query_valid(a_query_valid),
        .query_data(a_query_data), .reply_ready(a_reply_ready), .reply_valid(reply_valid),
        .reply_last(reply_last), .reply_data(reply_data), .result_valid(a_result_valid),
        .result_data(a_result_data), .overflow(a_overflow)
    );

    path_count_forward_pass #(.MAX_NODES(1024), .NODE_WIDTH(NW), .COUNT_WIDTH(CW_B)) dut_b (
        .clk(clk), .reset(reset), .start_node(start_node), .end_node(end_node),
        .order_ready(b_order_ready), .order_valid(order_valid), .order_node(order_node),
        .order_last(order_last), .query_ready(query_ready), .query_valid(b_query_valid),
        .query_data(b_query_data), .reply_ready(b_reply_ready), .reply_valid(reply_valid),
        .reply_last(reply_last), .reply_data(reply_data), .result_valid(b_result_valid),
        .result_data(b_result_data), .overflow(b_overflow)
    );

    typedef struct {
        int graph;      // 0 = diamond, 1 = 17-path ladder
        int start;
        int endn;
        int qstall;     // cycles query_ready is held low per query
        int rgap;       // idle cycles before each reply beat
        int exp_a;
        int exp_ovf_a;
        int exp_b;
        int exp_ovf_b;
        int exp_q;      // queries expected
    } vec_t;

    vec_t vecs[6];

    int succ_cnt[32];
    int succ[32][20];
    int ord[32];
    int olen;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic load_graph(input int g);
        for (int n = 0; n < 32; n++) succ_cnt[n] = 0;
        if (g == 0) begin
            succ[0][0] = 1; succ[0][1] = 2; succ_cnt[0] = 2;
            succ[1][0] = 3; succ_cnt[1] = 1;
            succ[2][0] = 3; succ_cnt[2] = 1;
            olen = 4;
        end else begin
            for (int k = 1; k <= 17; k++) begin
                succ[0][k-1] = k;
                succ[k][0]   = 18;
                succ_cnt[k]  = 1;
            end
            succ_cnt[0] = 17;
            olen = 19;
        end
        for (int n = 0; n < olen; n++) ord[n] = n;
    endtask

    // Applies reset, then feeds the order and plays the adjacency map until
    // the result pulse plus one DONE cycle has been observed. bad flags:
    // 1 handshakes active in DONE, 2 result not held, 4 timeout,
    // 8 query_data changed while stalled, 16 query_valid dropped while stalled.
    task automatic run_graph(input int qstall, input int rgap, input bit abort,
                             output int res_a, output int ovf_a,
                             output int res_b, output int ovf_b,
                             output int nq, output int npulse, output int bad);
        int oi = 0;
        int ri = 0;
        int nb = 0;
        int gap_cnt = 0;
        int stall_cnt = 0;
        int cyc = 0;
        int rnode = 0;
        int qnode = 0;
        int rr_seen = 0;
        bit o_fire = 1'b0;
        bit q_fire = 1'b0;
        bit r_fire = 1'b0;
        bit in_reply = 1'b0;
        bit q_pend = 1'b0;
        res_a = -1; ovf_a = -1; res_b = -1; ovf_b = -1;
        nq = 0; npulse = 0; bad = 0;
        order_valid = 1'b0; query_ready = 1'b0; reply_valid = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        forever begin
            // Retire handshakes that completed on the preceding rising edge.
            if (o_fire) oi++;
            if (r_fire) begin
                ri++;
                gap_cnt = rgap;
                if (ri == nb) in_reply = 1'b0;
            end
            if (q_fire) begin
                in_reply = 1'b1;
                ri = 0;
                rnode = qnode;
                nb = (succ_cnt[rnode] == 0) ? 1 : succ_cnt[rnode];
                gap_cnt = rgap;
                nq++;
            end
            if (npulse > 0) begin
                if (a_order_ready | a_query_valid | a_reply_ready | a_result_valid) bad |= 1;
                if (int'(a_result_data) != res_a) bad |= 2;
                break;
            end
            if (a_result_valid) begin
                npulse++;
                res_a = int'(a_result_data); ovf_a = int'(a_overflow);
                res_b = int'(b_result_data); ovf_b = int'(b_overflow);
            end
            if (abort && a_reply_ready) begin
                rr_seen++;
                if (rr_seen == 3) begin
                    reset = 1'b1;
                    order_valid = 1'b0; query_ready = 1'b0; reply_valid = 1'b0;
                    break;
                end
            end
            cyc++;
            if (cyc > 6000) begin
                bad |= 4;
                break;
            end
            // Order stream is offered from the first cycle, including CLEAR.
            order_valid = (oi < olen);
            order_node  = NW'(ord[(oi < olen) ? oi : 0]);
            order_last  = (oi == olen - 1);
            o_fire = order_valid && a_order_ready;
            query_ready = 1'b0;
            if (a_query_valid) begin
                if (!q_pend) begin
                    q_pend = 1'b1;
                    qnode = int'(a_query_data);
                    stall_cnt = qstall;
                end else if (int'(a_query_data) != qnode) begin
                    bad |= 8;
                end
                if (stall_cnt > 0) stall_cnt--;
                else query_ready = 1'b1;
            end else if (q_pend) begin
                bad |= 16;
            end
            q_fire = a_query_valid && query_ready;
            if (q_fire) q_pend = 1'b0;
            // Reply beats are held once raised, also across ACC_RD/ACC_WR.
            reply_valid = 1'b0; reply_last = 1'b0; reply_data = '0;
            if (in_reply && !abort) begin
                if (gap_cnt > 0) begin
                    gap_cnt--;
                end else begin
                    reply_valid = 1'b1;
                    reply_last  = (ri == nb - 1);
                    reply_data  = NW'((succ_cnt[rnode] == 0) ? rnode : succ[rnode][ri]);
                end
            end
            r_fire = reply_valid && a_reply_ready;
            @(negedge clk);
        end
    endtask

    initial begin
        int cnt;
        int others_bad;
        int ra, oa, rb, ob, nq, np, bad;

        //          graph start end qstall rgap exp_a ovf_a exp_b     ovf_b q
        vecs[0] = '{0,    0,    3,  0,     0,   2,    0,    2,        0,    3};
        vecs[1] = '{0,    5,    3,  0,     0,   0,    0,    0,        0,    0};
        vecs[2] = '{0,    0,    3,  7,     2,   2,    0,    2,        0,    3};
        vecs[3] = '{1,    0,    18, 0,     0,   17,   0,    LADDER_B, 1,    18};
        vecs[4] = '{0,    3,    3,  0,     0,   1,    0,    1,        0,    0};
        vecs[5] = '{0,    1,    3,  0,     1,   1,    0,    1,        0,    1};

        // Reset state, then CLEAR length and quiet outputs.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              int'(a_order_ready | a_query_valid | a_reply_ready | a_result_valid |
                   a_overflow | (|a_result_data) | (|a_query_data)), 0);
        reset = 1'b0;
        cnt = 0;
        others_bad = 0;
        while (!a_order_ready && cnt < 2000) begin
            cnt++;
            if (a_query_valid | a_reply_ready | a_result_valid | a_overflow |
                (|a_result_data) | (|a_query_data)) others_bad = 1;
            @(negedge clk);
        end
        $display("clear: order_ready low for %0d cycles", cnt);
        check("clear_cycles", cnt, 1024);
        check("clear_outputs_quiet", others_bad, 0);
        @(negedge clk);
        check("idle_ready", int'(a_order_ready), 1);

        for (int i = 0; i < 6; i++) begin
            load_graph(vecs[i].graph);
            start_node = NW'(vecs[i].start);
            end_node   = NW'(vecs[i].endn);
            run_graph(vecs[i].qstall, vecs[i].rgap, 1'b0, ra, oa, rb, ob, nq, np, bad);
            $display("vec %0d: start=%0d end=%0d result_a=%0d ovf_a=%0d result_b=%0d ovf_b=%0d queries=%0d pulses=%0d flags=%0d",
                     i, vecs[i].start, vecs[i].endn, ra, oa, rb, ob, nq, np, bad);
            check($sformatf("v%0d_result_a", i), ra, vecs[i].exp_a);
            check($sformatf("v%0d_overflow_a", i), oa, vecs[i].exp_ovf_a);
            check($sformatf("v%0d_result_b", i), rb, vecs[i].exp_b);
            check($sformatf("v%0d_overflow_b", i), ob, vecs[i].exp_ovf_b);
            check($sformatf("v%0d_queries", i), nq, vecs[i].exp_q);
            check($sformatf("v%0d_pulses", i), np, 1);
            check($sformatf("v%0d_protocol_flags", i), bad, 0);
        end

        // Reset while waiting in REPLY, then a clean rerun.
        load_graph(0);
        start_node = NW'(0);
        end_node   = NW'(3);
        run_graph(0, 0, 1'b1, ra, oa, rb, ob, nq, np, bad);
        check("abort_reached_reply", bad, 0);
        @(negedge clk);
        $display("mid-reply reset: order_ready=%0d query_valid=%0d reply_ready=%0d result_valid=%0d",
                 a_order_ready, a_query_valid, a_reply_ready, a_result_valid);
        check("mid_reset_outputs",
              int'(a_order_ready | a_query_valid | a_reply_ready | a_result_valid |
                   a_overflow | (|a_result_data) | (|a_query_data)), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_reset_in_clear", int'(a_order_ready), 0);
        run_graph(0, 0, 1'b0, ra, oa, rb, ob, nq, np, bad);
        $display("rerun: result_a=%0d ovf_a=%0d queries=%0d flags=%0d", ra, oa, nq, bad);
        check("rerun_result", ra, 2);
        check("rerun_overflow", oa, 0);
        check("rerun_flags", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
